// File: rtl/tpu_pkg.sv
// Shared TPU definitions: post-processing FSM states, memory strobe
// encoding and the shift/saturate helper.
package tpu_pkg;

    typedef enum logic [2:0] {
        PP_IDLE,
        PP_LOAD_B_REQ,
        PP_LOAD_B_WAIT,
        PP_RD_REQ,
        PP_RD_WAIT,
        PP_WR_REQ,
        PP_WR_WAIT,
        PP_DONE
    } pp_state_e;

    // Bit 0 is the read strobe, bit 1 the write strobe.
    typedef enum logic [1:0] {
        MEM_NOP = 2'b00,
        MEM_RD  = 2'b01,
        MEM_WR  = 2'b10
    } mem_op_e;

    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W:0] sat_shift(
        input logic signed [SAT_W:0] s,
        input logic        [4:0]     sh,
        input int                    w
    );
        logic signed [SAT_W:0] t;
        logic signed [SAT_W:0] one;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        one    = '0;
        one[0] = 1'b1;
        t  = s >>> sh;
        hi = (one <<< (w - 1)) - one;
        lo = -hi - one;
        if (t > hi) begin
            return hi;
        end
        if (t < lo) begin
            return lo;
        end
        return t;
    endfunction

endpackage

// File: rtl/matmul_postproc_lane.sv
// One element of the post-processing datapath:
// bias add, optional ReLU, arithmetic shift, signed saturation.
module postproc_lane
    import tpu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] bias,
    input  logic          relu_en,
    input  logic [4:0]    shift,
    output logic [DW-1:0] y
);

    logic signed [DW:0]    s;
    logic signed [SAT_W:0] w;
    logic signed [SAT_W:0] r;
    logic                  unused_hi;

    always_comb begin
        // Sign-extended operands make the DW+1 bit sum exact.
        s = {x[DW-1], x} + {bias[DW-1], bias};
        if (relu_en && s[DW]) begin
            s = '0;
        end
        w = {{(SAT_W - DW){s[DW]}}, s};
        r = sat_shift(w, shift, DW);
        y = r[DW-1:0];
    end

    assign unused_hi = ^r[SAT_W:DW];

endmodule

// File: rtl/matmul_postproc.sv
// Post-processing of the systolic result matrix: bias load, per-beat
// read / compute / write-back over the fixed-latency memory port.
module matmul_postproc
    import tpu_pkg::*;
#(
    parameter int N              = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int BANKING_FACTOR = 1,
    parameter int ADDRESS_WIDTH  = 13,
    parameter int MEM_LATENCY    = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    output logic                                 done,
    output logic                                 busy,
    input  logic [ADDRESS_WIDTH-1:0]             base_addr_in,
    input  logic [ADDRESS_WIDTH-1:0]             base_addr_bias,
    input  logic [ADDRESS_WIDTH-1:0]             base_addr_out,
    input  logic                                 bias_en,
    input  logic                                 relu_en,
    input  logic [4:0]                           shift,
    output logic [ADDRESS_WIDTH-1:0]             mem_req_addr,
    output logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_req_data,
    input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_resp_data,
    output logic                                 mem_read_en,
    output logic                                 mem_write_en
);

    localparam int DW      = DATA_WIDTH;
    localparam int BF      = BANKING_FACTOR;
    localparam int AW      = ADDRESS_WIDTH;
    localparam int NB_BIAS = (N + BF - 1) / BF;
    localparam int NB      = (N * N + BF - 1) / BF;
    localparam int TW      = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [AW-1:0] LAST_BIAS = AW'(NB_BIAS - 1);
    localparam logic [AW-1:0] LAST_BEAT = AW'(NB - 1);
    localparam logic [TW-1:0] LAST_T    = TW'(MEM_LATENCY - 1);

    pp_state_e         state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [AW-1:0]     beat_q, beat_d;
    logic [AW-1:0]     b_in_q, b_in_d;
    logic [AW-1:0]     b_bias_q, b_bias_d;
    logic [AW-1:0]     b_out_q, b_out_d;
    logic              bias_en_q, bias_en_d;
    logic              relu_en_q, relu_en_d;
    logic [4:0]        shift_q, shift_d;
    logic [DW-1:0]     bias_buf_q [N];
    logic [DW-1:0]     bias_buf_d [N];
    mem_op_e           op_q, op_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [BF*DW-1:0]  wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [DW-1:0]     lane_bias [BF];
    logic              lane_ok [BF];
    logic [DW-1:0]     lane_raw [BF];
    logic [BF*DW-1:0]  lane_y;

    always_comb begin
        for (int b = 0; b < BF; b++) begin
            int f;
            f = int'(beat_q) * BF + b;
            lane_bias[b] = '0;
            lane_ok[b]   = (f < N * N);
            for (int i = 0; i < N; i++) begin
                if (bias_en_q && (f % N == i)) begin
                    lane_bias[b] = bias_buf_q[i];
                end
            end
        end
    end

    for (genvar g = 0; g < BF; g++) begin : g_lane
        postproc_lane #(.DW(DW)) u_lane (
            .x       (mem_resp_data[g*DW +: DW]),
            .bias    (lane_bias[g]),
            .relu_en (relu_en_q),
            .shift   (shift_q),
            .y       (lane_raw[g])
        );
        assign lane_y[g*DW +: DW] = lane_ok[g] ? lane_raw[g] : '0;
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        beat_d     = beat_q;
        b_in_d     = b_in_q;
        b_bias_d   = b_bias_q;
        b_out_d    = b_out_q;
        bias_en_d  = bias_en_q;
        relu_en_d  = relu_en_q;
        shift_d    = shift_q;
        bias_buf_d = bias_buf_q;
        op_d       = MEM_NOP;
        addr_d     = '0;
        wdata_d    = '0;
        done_d     = 1'b0;

        unique case (state_q)
            PP_IDLE: begin
                if (start) begin
                    b_in_d    = base_addr_in;
                    b_bias_d  = base_addr_bias;
                    b_out_d   = base_addr_out;
                    bias_en_d = bias_en;
                    relu_en_d = relu_en;
                    shift_d   = shift;
                    beat_d    = '0;
                    op_d      = MEM_RD;
                    if (bias_en) begin
                        state_d = PP_LOAD_B_REQ;
                        addr_d  = base_addr_bias;
                    end else begin
                        state_d = PP_RD_REQ;
                        addr_d  = base_addr_in;
                    end
                end
            end
            PP_LOAD_B_REQ: begin
                state_d = PP_LOAD_B_WAIT;
                timer_d = '0;
            end
            PP_LOAD_B_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (timer_q >= LAST_T) begin
                    for (int i = 0; i < N; i++) begin
                        for (int b = 0; b < BF; b++) begin
                            if (int'(beat_q) * BF + b == i) begin
                                bias_buf_d[i] = mem_resp_data[b*DW +: DW];
                            end
                        end
                    end
                    op_d = MEM_RD;
                    if (beat_q == LAST_BIAS) begin
                        beat_d  = '0;
                        state_d = PP_RD_REQ;
                        addr_d  = b_in_q;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = PP_LOAD_B_REQ;
                        addr_d  = b_bias_q + beat_q + 1'b1;
                    end
                end
            end
            PP_RD_REQ: begin
                state_d = PP_RD_WAIT;
                timer_d = '0;
            end
            PP_RD_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (timer_q >= LAST_T) begin
                    state_d = PP_WR_REQ;
                    op_d    = MEM_WR;
                    addr_d  = b_out_q + beat_q;
                    wdata_d = lane_y;
                end
            end
            PP_WR_REQ: begin
                state_d = PP_WR_WAIT;
                timer_d = '0;
            end
            PP_WR_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (timer_q >= LAST_T) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = PP_DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = PP_RD_REQ;
                        op_d    = MEM_RD;
                        addr_d  = b_in_q + beat_q + 1'b1;
                    end
                end
            end
            PP_DONE: begin
                state_d = PP_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = PP_IDLE;
        endcase

        busy_d = (state_d != PP_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PP_IDLE;
            timer_q    <= '0;
            beat_q     <= '0;
            b_in_q     <= '0;
            b_bias_q   <= '0;
            b_out_q    <= '0;
            bias_en_q  <= 1'b0;
            relu_en_q  <= 1'b0;
            shift_q    <= '0;
            bias_buf_q <= '{default: '0};
            op_q       <= MEM_NOP;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            beat_q     <= beat_d;
            b_in_q     <= b_in_d;
            b_bias_q   <= b_bias_d;
            b_out_q    <= b_out_d;
            bias_en_q  <= bias_en_d;
            relu_en_q  <= relu_en_d;
            shift_q    <= shift_d;
            bias_buf_q <= bias_buf_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign done         = done_q;
    assign busy         = busy_q;
    assign mem_req_addr = addr_q;
    assign mem_req_data = wdata_q;
    assign mem_read_en  = op_q[0];
    assign mem_write_en = op_q[1];

endmodule

// File: tb/tb_matmul_postproc.sv
// Directed bench for matmul_postproc: BF=1 instance for the main
// vectors, BF=2 instance for the in-place run.
module tb_matmul_postproc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- BF=1 instance ----------------
    logic        start = 1'b0;
    logic        done, busy;
    logic [12:0] base_in = '0, base_bias = '0, base_out = '0;
    logic        bias_en = 1'b0, relu_en = 1'b0;
    logic [4:0]  shift = '0;
    logic [12:0] addr1;
    logic [31:0] wdata1, resp1;
    logic        rd1, wr1;

    matmul_postproc u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done), .busy(busy),
        .base_addr_in(base_in), .base_addr_bias(base_bias),
        .base_addr_out(base_out), .bias_en(bias_en), .relu_en(relu_en),
        .shift(shift), .mem_req_addr(addr1), .mem_req_data(wdata1),
        .mem_resp_data(resp1), .mem_read_en(rd1), .mem_write_en(wr1)
    );

    logic [31:0] mem1 [256];
    logic [31:0] p1 [3];
    int rdc1 = 0, wrc1 = 0, brd1 = 0, viol1 = 0, dcnt = 0;
    assign resp1 = p1[2];

    always @(posedge clk) begin
        p1[0] <= rd1 ? mem1[addr1[7:0]] : 32'hDEADBEEF;
        p1[1] <= p1[0];
        p1[2] <= p1[1];
        if (wr1) mem1[addr1[7:0]] <= wdata1;
        if (rd1) rdc1 <= rdc1 + 1;
        if (wr1) wrc1 <= wrc1 + 1;
        if (rd1 && addr1 >= 13'h040 && addr1 < 13'h050) brd1 <= brd1 + 1;
        if ((rd1 && wr1) || (!rd1 && !wr1 && (addr1 != 0 || wdata1 != 0)))
            viol1 <= viol1 + 1;
        if (done) dcnt <= dcnt + 1;
    end

    // ---------------- BF=2 instance ----------------
    logic        start2 = 1'b0;
    logic        done2, busy2;
    logic [12:0] addr2;
    logic [63:0] wdata2, resp2;
    logic        rd2, wr2;

    matmul_postproc #(.BANKING_FACTOR(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .done(done2),
        .busy(busy2), .base_addr_in(13'h008), .base_addr_bias(13'h004),
        .base_addr_out(13'h008), .bias_en(1'b1), .relu_en(1'b0),
        .shift(5'd0), .mem_req_addr(addr2), .mem_req_data(wdata2),
        .mem_resp_data(resp2), .mem_read_en(rd2), .mem_write_en(wr2)
    );

    logic [63:0] mem2 [64];
    logic [63:0] p2 [3];
    logic [12:0] last_rd2 = '0;
    int rdc2 = 0, wrc2 = 0, alt2 = 0;
    assign resp2 = p2[2];

    always @(posedge clk) begin
        p2[0] <= rd2 ? mem2[addr2[5:0]] : 64'hDEADBEEF_DEADBEEF;
        p2[1] <= p2[0];
        p2[2] <= p2[1];
        if (wr2) mem2[addr2[5:0]] <= wdata2;
        if (rd2) begin
            rdc2 <= rdc2 + 1;
            last_rd2 <= addr2;
        end
        if (wr2) wrc2 <= wrc2 + 1;
        if (wr2 && addr2 != last_rd2) alt2 <= alt2 + 1;
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad = 0;
    int src [16];
    int expv [16];
    int bia [4];

    task automatic check(input string tag, input int idx,
                         input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d]: got %h want %h", tag, idx, obs, exp);
        end
    endtask

    task automatic run1(input int glitch, output int lat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        base_in = 13'h0F0;
        base_bias = 13'h0F8;
        base_out = 13'h0E0;
        bias_en = ~bias_en;
        relu_en = ~relu_en;
        shift = ~shift;
        lat = 0;
        while (done !== 1'b1 && lat < 1000) begin
            start = (lat == glitch);
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic test1(input string tag, input logic be, input logic re,
                         input logic [4:0] sh, input int glitch,
                         input logic [12:0] out_base);
        int lat, r0, w0, b0, d0;
        for (int i = 0; i < 16; i++) mem1[8'h10 + i] = src[i];
        for (int k = 0; k < 4; k++) mem1[8'h40 + k] = bia[k];
        base_in = 13'h010;
        base_bias = 13'h040;
        base_out = out_base;
        bias_en = be;
        relu_en = re;
        shift = sh;
        r0 = rdc1; w0 = wrc1; b0 = brd1; d0 = dcnt;
        run1(glitch, lat);
        check({tag, "_lat"}, 0, lat, be ? 145 : 129);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 0, {31'd0, done}, 0);
        check({tag, "_busy_idle"}, 0, {31'd0, busy}, 0);
        check({tag, "_done_cnt"}, 0, dcnt - d0, 1);
        check({tag, "_bias_rd"}, 0, brd1 - b0, be ? 4 : 0);
        check({tag, "_rd"}, 0, rdc1 - r0, be ? 20 : 16);
        check({tag, "_wr"}, 0, wrc1 - w0, 16);
        for (int i = 0; i < 16; i++)
            check({tag, "_out"}, i, mem1[out_base[7:0] + 8'(i)], expv[i]);
    endtask

    initial begin
        int lat2, d0;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", 0, {31'd0, done}, 0);
        check("rst_busy", 0, {31'd0, busy}, 0);
        check("rst_rd", 0, {31'd0, rd1}, 0);
        check("rst_wr", 0, {31'd0, wr1}, 0);
        check("rst_addr", 0, {19'd0, addr1}, 0);
        check("rst_data", 0, wdata1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // bias add, defaults
        bia = '{100, 200, 300, 400};
        for (int i = 0; i < 16; i++) src[i] = i;
        expv = '{100, 201, 302, 403, 104, 205, 306, 407,
                 108, 209, 310, 411, 112, 213, 314, 415};
        test1("bias", 1'b1, 1'b0, 5'd0, -1, 13'h080);

        // relu + shift 2, no bias
        src  = '{-8, 7, -1, 13, 100, -100, 3, 4,
                 32'h80000000, 32'h7FFFFFFF, 16, -16, 0, 1, 5, 1024};
        expv = '{0, 1, 0, 3, 25, 0, 0, 1,
                 0, 32'h1FFFFFFF, 4, 0, 0, 0, 1, 256};
        test1("relu", 1'b0, 1'b1, 5'd2, -1, 13'h080);

        // saturation, shift 0
        bia = '{32'h20, -1, 5, -5};
        for (int i = 0; i < 16; i += 4) begin
            src[i] = 32'h7FFFFFF0; src[i+1] = 32'h80000000;
            src[i+2] = 10; src[i+3] = -10;
            expv[i] = 32'h7FFFFFFF; expv[i+1] = 32'h80000000;
            expv[i+2] = 15; expv[i+3] = -15;
        end
        test1("sat", 1'b1, 1'b0, 5'd0, -1, 13'h080);

        // floor rounding of negative values, shift 3
        for (int i = 0; i < 16; i += 4) begin
            src[i] = -9; src[i+1] = -8; src[i+2] = 9; src[i+3] = -1;
            expv[i] = -2; expv[i+1] = -1; expv[i+2] = 1; expv[i+3] = -1;
        end
        test1("floor", 1'b0, 1'b0, 5'd3, -1, 13'h080);

        // start pulse at cycle 20 ignored
        bia = '{100, 200, 300, 400};
        for (int i = 0; i < 16; i++) src[i] = i;
        expv = '{100, 201, 302, 403, 104, 205, 306, 407,
                 108, 209, 310, 411, 112, 213, 314, 415};
        for (int i = 0; i < 16; i++) mem1[8'h80 + i] = 32'h5555_5555;
        test1("glitch", 1'b1, 1'b0, 5'd0, 20, 13'h080);

        // async reset at cycle 50
        for (int i = 0; i < 16; i++) mem1[8'hA0 + i] = 32'h5555_5555;
        base_in = 13'h010;
        base_bias = 13'h040;
        base_out = 13'h0A0;
        bias_en = 1'b1;
        relu_en = 1'b0;
        shift = 5'd0;
        d0 = dcnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #2;
        check("abort_busy_before", 0, {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 0, {31'd0, busy}, 0);
        check("abort_done", 0, {31'd0, done}, 0);
        check("abort_rd", 0, {31'd0, rd1}, 0);
        check("abort_wr", 0, {31'd0, wr1}, 0);
        check("abort_addr", 0, {19'd0, addr1}, 0);
        check("abort_data", 0, wdata1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(posedge clk);
        #1;
        check("abort_no_done", 0, dcnt - d0, 0);
        test1("restart", 1'b1, 1'b0, 5'd0, -1, 13'h0A0);

        // in-place run, two lanes per beat
        mem2[4] = {32'd200, 32'd100};
        mem2[5] = {32'd400, 32'd300};
        for (int k = 0; k < 8; k++) mem2[8 + k] = {32'(2*k + 1), 32'(2*k)};
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        lat2 = 0;
        while (done2 !== 1'b1 && lat2 < 1000) begin
            @(posedge clk);
            #1;
            lat2++;
        end
        check("bf2_lat", 0, lat2, 73);
        check("bf2_rd", 0, rdc2, 10);
        check("bf2_wr", 0, wrc2, 8);
        check("bf2_alt", 0, alt2, 0);
        for (int i = 0; i < 16; i++)
            check("bf2_out", i, mem2[8 + i/2][(i%2)*32 +: 32], expv[i]);

        check("strobe_viol", 0, viol1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_postproc.md
# matmul_postproc

Post-processing stage directly downstream of the systolic matmul wrapper. After the wrapper's `done`, control starts this block. It reads the N×N row-major result matrix from unified memory and applies per-column bias add, optional ReLU, arithmetic right shift and signed saturation. It writes the result back to memory over the same fixed-latency port protocol the wrapper uses.

## Interface
- `N`, 4, matrix dimension (result is N×N, bias is N entries)
- `DATA_WIDTH`, 32, signed element width
- `BANKING_FACTOR`, 1, elements per memory beat
- `ADDRESS_WIDTH`, 13, memory address width (beat-granular)
- `MEM_LATENCY`, 3, fixed read/write latency in cycles (≥1)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle launch pulse; honoured only in IDLE
- `done`  out  1  one-cycle pulse when all writes have completed
- `busy`  out  1  high in every state except IDLE
- `base_addr_in`  in  ADDRESS_WIDTH  beat address of source matrix
- `base_addr_bias`  in  ADDRESS_WIDTH  beat address of N-entry bias vector
- `base_addr_out`  in  ADDRESS_WIDTH  beat address of destination; may equal `base_addr_in` (in-place)
- `bias_en`  in  1  1: load and add bias; 0: bias treated as 0, bias load skipped
- `relu_en`  in  1  clamp negatives to 0
- `shift`  in  5  arithmetic right-shift amount
- `mem_req_addr`  out  ADDRESS_WIDTH  request address
- `mem_req_data`  out  BANKING_FACTOR*DATA_WIDTH  write data, element b at bits [b*DATA_WIDTH +: DATA_WIDTH]
- `mem_resp_data`  in  BANKING_FACTOR*DATA_WIDTH  read data
- `mem_read_en`, `mem_write_en`  out  1  one-cycle request strobes, never both high

## Operation
- All outputs are registered.
- Reset values:
  - all outputs 0
  - state IDLE
  - bias buffer and beat index cleared
- `start` in IDLE latches all three base addresses, `bias_en`, `relu_en` and `shift`. Later changes to these inputs have no effect until the next start.
- FSM states: IDLE → LOAD_B_REQ ⇄ LOAD_B_WAIT → RD_REQ → RD_WAIT → WR_REQ → WR_WAIT → (RD_REQ | DONE) → IDLE.
  - When `bias_en`=0, IDLE goes straight to RD_REQ.
- Bias load:
  - ceil(N/BANKING_FACTOR) beats from `base_addr_bias`+k.
  - Elements with flat index ≥ N are discarded.
- Per beat j, 0…ceil(N²/BANKING_FACTOR)−1:
  - Read `base_addr_in`+j.
  - Compute all BANKING_FACTOR lanes.
  - Write `base_addr_out`+j.
  - Read and write of a beat never overlap, so in-place operation is safe.
- Lane arithmetic, for flat index f = j*BANKING_FACTOR+b and column c = f mod N:
  1. s = sext(x) + sext(bias[c]), computed at DATA_WIDTH+1 bits with no wrap.
  2. If `relu_en` and s<0, then s=0.
  3. s = s >>> shift (floor toward −∞).
  4. Saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- Lanes with f ≥ N² write 0.
- `start` while busy is ignored: no relatch, no restart.
- `rst_n` asserted mid-operation returns immediately to reset values. No `done` is issued, partial writes remain in memory, and the next `start` runs from the beginning.

## Timing
- A REQ state drives the address plus one strobe for exactly one cycle, then enters WAIT with timer=0.
- WAIT increments the timer each cycle and leaves when timer ≥ MEM_LATENCY−1. On that cycle read data is sampled from `mem_resp_data`.
  - Read data is therefore sampled MEM_LATENCY cycles after the strobe cycle.
- Each beat costs 2*(MEM_LATENCY+1) cycles. The bias load costs (MEM_LATENCY+1) per beat.
- Lane computation is done combinationally from the registered read data and registered into `mem_req_data` in WR_REQ. There is no extra pipeline cycle.
- `mem_req_addr` and `mem_req_data` are 0 in every cycle without a strobe.
- `done` rises the cycle after the last WR_WAIT exits. `busy` falls in that same cycle.
- Total cycles from the start edge to `done` with defaults and `bias_en`=1: 4*4 + 16*8 + 1 = 145.

## Structure
- The shared package `tpu_pkg` holds:
  - the postproc state enum
  - a `sat_shift` width-parametric helper function
  - the memory strobe encoding shared with the systolic wrapper
- One sub-module, `postproc_lane`: purely combinational bias/ReLU/shift/saturate for one element, instantiated BANKING_FACTOR times via generate.
- The top level holds the FSM, latency timer, beat counter and bias buffer.

## Test plan
- Defaults, `bias_en`=1, `relu_en`=0, `shift`=0. Source element (r,c) = r*4+c, bias = {100, 200, 300, 400} → out(r,c) = r*4+c + bias[c]. `done` at cycle 145. Exactly 4 bias reads, 16 reads, 16 writes.
- `relu_en`=1, `shift`=2, `bias_en`=0. Source {−8, 7, −1, 13, …} → {0, 1, 0, 3, …}. No bias reads are issued.
- Saturation with `shift`=0:
  - x = 0x7FFFFFF0, bias = 0x20 → 0x7FFFFFFF
  - x = 0x80000000, bias = −1 → 0x80000000
- In-place run (`base_addr_out`=`base_addr_in`) with BANKING_FACTOR=2 gives results identical to the out-of-place run. The read and write for each beat alternate.
- A `start` pulse at cycle 20 of a run is ignored: the final data and `done` timing are unchanged.
- `rst_n` pulsed low at cycle 50:
  - all outputs go to 0 asynchronously and `done` never fires
  - a fresh `start` then completes normally in 145 cycles
